// File: rtl/token_pkg.sv
// token_pkg: shared FSM state type and timer sizing for token_window_counter
package token_pkg;
  typedef enum logic [1:0] {IDLE, COUNT, HOLD} token_win_state_t;
  function automatic int timer_width(input int window);
    return $clog2(window + 1);
  endfunction
endpackage

// File: rtl/window_timer.sv
// window_timer: loadable down-counter, done pulses on the last enabled cycle
module window_timer #(
  parameter int WINDOW = 8,
  parameter int W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= W'(WINDOW);
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  assign done = en && cnt == W'(1);
endmodule

// File: rtl/token_window_counter.sv
// token_window_counter: counts 1-tokens over WINDOW cycles, result on valid/ready; TOKEN_WINDOW_AUTO_RESTART_EN makes every handshake restart a window
module token_window_counter
  import token_pkg::*;
#(
  parameter int WINDOW = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             a,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  input  logic             count_ready,
  output logic             overflow
);
  localparam int TW = timer_width(WINDOW);
  localparam logic [CNT_W-1:0] MAX = '1;
`ifdef TOKEN_WINDOW_AUTO_RESTART_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  token_win_state_t state, state_n;
  logic hs, go, done;
  assign hs = state == HOLD && count_ready;
  assign go = (state == IDLE && start) || (hs && (start || AUTO));
  window_timer #(.WINDOW(WINDOW), .W(TW)) u_timer (
    .clk (clk),
    .rst (rst),
    .load(go),
    .en  (state == COUNT),
    .done(done)
  );
  always_comb begin
    state_n = state;
    state_n = go ? COUNT : (state == COUNT && done) ? HOLD : hs ? IDLE : state;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk)
    if (rst || go) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (state == COUNT && a) begin
      if (count == MAX) overflow <= 1'b1;
      else count <= count + 1'b1;
    end
  assign busy        = state != IDLE;
  assign count_valid = state == HOLD;
endmodule

// File: doc/token_window_counter.md
# token_window_counter

Downstream measurement stage for the serial token path: consumes the 1-bit token stream produced by the token-halving stage and counts `1` tokens over a fixed window of clock cycles. At the end of each window it presents the count on a valid/ready output port and holds it until the consumer accepts it. It is used to check token rates after rate-reduction stages and to feed rate statistics to control logic.

## Interface

- `WINDOW`, default 8: window length in clock cycles; must be ≥ 1.
- `CNT_W`, default 4: count width in bits; must be ≥ 1.
- `clk`, in, 1: clock; all logic is rising-edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: request a measurement window; sampled only in IDLE, or in HOLD during the handshake cycle.
- `a`, in, 1: serial token input; a `1` is one token.
- `busy`, out, 1: high in COUNT and HOLD.
- `count`, out, CNT_W: token count of the completed window; valid while `count_valid` is high.
- `count_valid`, out, 1: result available.
- `count_ready`, in, 1: consumer accepts the result.
- `overflow`, out, 1: the count saturated during this window; qualified by `count_valid`.

## Operation

- FSM states: IDLE, COUNT, HOLD.
- IDLE:
  - `start`=1 moves to COUNT on the next cycle.
  - On that transition, clear the count register and the overflow flag, and load the window timer with `WINDOW`.
- COUNT:
  - Sample `a` every cycle for exactly `WINDOW` cycles.
  - When `a`=1, increment the count. At 2^CNT_W−1 the count saturates and `overflow` is set (sticky for the window).
  - After the last sample cycle, move to HOLD.
  - `start` is ignored in COUNT.
- HOLD:
  - `count_valid`=1. `count` and `overflow` are stable.
  - `a` is ignored; tokens arriving in HOLD are not counted.
- Handshake in HOLD (`count_valid` and `count_ready` both high):
  - With `start`=0: go to IDLE.
  - With `start`=1: go directly to COUNT, with the clear and timer load described for IDLE.
- `count_ready` outside HOLD has no effect. `start` in HOLD without a handshake is ignored.
- Reset values: `busy`=0, `count`=0, `count_valid`=0, `overflow`=0. The FSM resets to IDLE and the timer to 0.
- Reset during COUNT or HOLD aborts the window. The partial count is discarded and no result is presented.

## Timing

- `start` sampled high at cycle t (IDLE): samples of `a` are taken at cycles t+1 through t+WINDOW, and `count_valid` rises at cycle t+WINDOW+1.
- The token at the last sample cycle is included in the count.
- Handshake at cycle h: `count_valid` is low at h+1.
- Back-to-back windows (`start` at the handshake cycle): the next window's first sample is at h+1. There is no IDLE cycle between windows.
- No combinational path from `count_ready` or `start` to any output. All outputs are registered.

## Configuration

- `TOKEN_WINDOW_AUTO_RESTART_EN` defined:
  - Every handshake in HOLD behaves as if `start`=1, so windows run back to back after the first `start`.
  - IDLE is re-entered only through `rst`.
- `TOKEN_WINDOW_AUTO_RESTART_EN` undefined: `start` is required for every window, as described in Operation.

## Structure

- Shared package `token_pkg`:
  - state enum typedef `token_win_state_t` (IDLE, COUNT, HOLD);
  - a function computing the timer width as clog2(WINDOW+1).
- Sub-module `window_timer`:
  - loadable down-counter, loaded with `WINDOW`;
  - produces a single-cycle `done` pulse on the last sample cycle;
  - instantiated once.

## Test plan

- Reset: hold `rst` 2 cycles with `a`=1 and `start`=1 → `busy`, `count`, `count_valid`, `overflow` all 0, and no window starts.
- Basic count (WINDOW=8, CNT_W=4): `start` at cycle 0, `a` = 1,0,1,1,0,0,1,1 on cycles 1–8 → `count_valid`=1 at cycle 9 with `count`=5 and `overflow`=0.
- Backpressure: in HOLD, `count_ready`=0 for 5 cycles while `a` toggles → `count` stays 5 and `count_valid` stays 1 throughout. Raise `count_ready` → `count_valid`=0 the next cycle.
- Saturation (CNT_W=2, WINDOW=8): `a`=1 for all 8 sample cycles → `count`=3, `overflow`=1.
- Back-to-back windows: `start`=1 in the handshake cycle h with `a`=1 constant → second result has `count_valid` at h+9 and `count`=8 (WINDOW=8, CNT_W=4). With `TOKEN_WINDOW_AUTO_RESTART_EN` defined, the same result occurs with `start` held 0.
- Reset mid-window: `rst` at the 4th sample cycle → IDLE next cycle with `count_valid`=0. A new `start` with 2 tokens in its window gives `count`=2.
